// File: rtl/etpu_wb_initiator.sv
// Wishbone classic single-beat initiator: turns word-burst commands into one
// Wishbone cycle per word, streaming write data in and read data out.
module etpu_wb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_W/8-1:0]   cmd_sel,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  done,
  output logic                  err,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [DATA_W-1:0]     wbm_dat_i
);
  // state | meaning
  // IDLE  | waiting for a command, cmd_ready=1
  // FETCH | write beat: waiting for the write word
  // BUS   | cyc/stb asserted, waiting for ack or timeout
  // RESP  | read word held on rdata until consumed
  // NEXT  | inter-beat gap: advance address or finish
  // DONE  | one-cycle done pulse, err valid

  localparam int SEL_W = DATA_W / 8;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(SEL_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_BUS, S_RESP, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [LEN_W-1:0]    beat_q;
  logic [TO_W-1:0]     to_q;
  logic                err_q;
  logic                timeout_hit;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_we ? S_FETCH : S_BUS;
      end
      S_FETCH: begin
        wdata_ready = 1'b1;
        if (wdata_valid) state_d = S_BUS;
      end
      S_BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        // an ack in the last allowed cycle still completes the beat
        if (wbm_ack_i) begin
          state_d = we_q ? S_NEXT : S_RESP;
        end else if (TIMEOUT != 0 && to_q == '0) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_RESP: begin
        rdata_valid = 1'b1;
        if (rdata_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (beat_q == '0) state_d = S_DONE;
        else              state_d = we_q ? S_FETCH : S_BUS;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      to_q    <= TO_LOAD;
      err_q   <= 1'b0;
    end else begin
      to_q <= (state_q == S_BUS) ? to_q - TO_W'(1) : TO_LOAD;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            we_q   <= cmd_we;
            adr_q  <= cmd_addr & ADDR_MASK;
            sel_q  <= cmd_sel;
            beat_q <= cmd_len;
            err_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (wdata_valid) dat_q <= wdata;
        end
        S_BUS: begin
          if (wbm_ack_i && !we_q) rdata_q <= wbm_dat_i;
          if (timeout_hit) err_q <= 1'b1;
        end
        S_NEXT: begin
          if (beat_q != '0) begin
            adr_q  <= adr_q + ADDR_STEP;
            beat_q <= beat_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = sel_q;
  assign wbm_dat_o = dat_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_etpu_wb_initiator.sv
// Bench for etpu_wb_initiator: table of single-beat commands plus directed
// sequences for bursts, stalls, timeout, address wrap, spurious acks and reset.
module tb_etpu_wb_initiator;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        wb_rst_i, cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic        done, err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;

  always #5 clk = ~clk;

  etpu_wb_initiator #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .err(err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // responder: acks ack_dly+1 cycles after stb rises, never if resp_en=0
  logic ack_r = 1'b0, spur_ack = 1'b0, resp_en = 1'b1;
  int   ack_dly = 0, wcnt = 0;
  assign wbm_ack_i = ack_r | spur_ack;
  assign wbm_dat_i = ack_r ? rd_word(wbm_adr_o) : 32'h0BAD_0BAD;

  always @(negedge clk) begin
    if (wbm_stb_o && !ack_r && resp_en) begin
      if (wcnt == ack_dly + 1) ack_r = 1'b1;
      else wcnt++;
    end else begin
      ack_r = 1'b0;
      wcnt  = 0;
    end
  end

  // bus monitor
  logic [31:0] adr_log[$], dat_log[$];
  logic        we_log[$];
  logic [3:0]  sel_log[$];
  int stb_cycles = 0, done_cnt = 0, err_cnt = 0, unstable = 0;
  int cyc_no = 0, t_stb = 0, t_rv = 0;
  logic stb_prev = 1'b0, rv_prev = 1'b0;
  logic [31:0] adr_prev = '0;

  always @(posedge clk) cyc_no++;

  always @(negedge clk) begin
    if (wbm_stb_o) begin
      stb_cycles++;
      if (!stb_prev) begin
        adr_log.push_back(wbm_adr_o);
        dat_log.push_back(wbm_dat_o);
        we_log.push_back(wbm_we_o);
        sel_log.push_back(wbm_sel_o);
        t_stb = cyc_no;
      end else if (wbm_adr_o != adr_prev) begin
        unstable++;
      end
      if (!wbm_cyc_o) unstable++;
    end
    if (rdata_valid && !rv_prev) t_rv = cyc_no;
    if (done) begin
      done_cnt++;
      if (err) err_cnt++;
    end
    stb_prev = wbm_stb_o;
    rv_prev  = rdata_valid;
    adr_prev = wbm_adr_o;
  end

  int n_checks = 0, n_fail = 0;
  int b_adr, b_stb, b_done, b_err, b_uns;
  logic [31:0] rd_q[$];
  bit r_err, r_tmo;
  int r_accw, r_early, r_sstb, r_srv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mark();
    b_adr  = adr_log.size();
    b_stb  = stb_cycles;
    b_done = done_cnt;
    b_err  = err_cnt;
    b_uns  = unstable;
    rd_q.delete();
  endtask

  function automatic int nbeats();
    return adr_log.size() - b_adr;
  endfunction
  function automatic logic [31:0] adr_at(input int i);
    return (b_adr + i < adr_log.size()) ? adr_log[b_adr + i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] dat_at(input int i);
    return (b_adr + i < dat_log.size()) ? dat_log[b_adr + i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [7:0] we_sel_at(input int i);
    return (b_adr + i < we_log.size()) ? {3'b000, we_log[b_adr + i], sel_log[b_adr + i]} : 8'hFF;
  endfunction
  function automatic logic [31:0] rd_at(input int i);
    return (i < rd_q.size()) ? rd_q[i] : 32'hFFFF_FFFF;
  endfunction

  // Drives one command to completion (done seen) or until beat rst_beat's stb rises.
  task automatic run_burst(input logic we, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] sel, input logic [31:0] wbase,
                           input int stall_beat, input int stall_n, input bit spur,
                           input int wgap, input bit hold, input int rst_beat);
    bit accepted;
    int widx, ridx, left, gap, rises;
    logic sp;
    accepted = 0; widx = 0; ridx = 0; left = stall_n; gap = 0; rises = 0; sp = 1'b0;
    r_err = 0; r_tmo = 1; r_accw = 0; r_early = 0; r_sstb = 0; r_srv = 0;
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (wbm_stb_o && !sp) rises++;
      sp = wbm_stb_o;
      if (rst_beat > 0 && wbm_stb_o && rises == rst_beat) begin
        wb_rst_i = 1'b1; cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
        spur_ack = 1'b0; r_tmo = 0;
        break;
      end
      if (done && accepted) begin
        r_err = err; r_tmo = 0;
        cmd_valid = hold; wdata_valid = 1'b0; rdata_ready = 1'b0; spur_ack = 1'b0;
        break;
      end
      cmd_valid = hold ? 1'b1 : !accepted;
      if (cmd_valid && cmd_ready) begin
        if (accepted) r_early++;
        accepted = 1;
      end else if (!accepted) begin
        r_accw++;
      end
      spur_ack = spur && !wbm_cyc_o;
      if (wdata_ready) begin
        if (gap < wgap) begin
          wdata_valid = 1'b0; gap++;
        end else begin
          wdata_valid = 1'b1; wdata = wbase + widx; widx++; gap = 0;
        end
      end else begin
        wdata_valid = 1'b0;
      end
      if (rdata_valid) begin
        if (ridx == stall_beat && left > 0) begin
          rdata_ready = 1'b0; left--; r_srv++;
          if (wbm_stb_o) r_sstb++;
        end else begin
          rdata_ready = 1'b1; rd_q.push_back(rdata); ridx++;
        end
      end else begin
        rdata_ready = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_adr;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t vecs[4];
    vecs[0] = '{1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 0, 32'h3000_0004, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0013, 4'h3, 32'h0,         0, 32'h3000_0010, 32'h9500_0010};
    vecs[2] = '{1'b1, 32'h1234_5677, 4'h5, 32'h0123_4567, 1, 32'h1234_5674, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         2, 32'h0000_0008, 32'hA500_0008};

    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 wb_rst_i = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
    chk("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 0);
    chk("rst_flags", {done, err, rdata_valid, wdata_ready}, 0);
    chk("rst_rdata", rdata, 0);

    for (int i = 0; i < 4; i++) begin
      ack_dly = vecs[i].dly;
      mark();
      run_burst(vecs[i].we, vecs[i].addr, 8'd0, vecs[i].sel, vecs[i].wdata, -1, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("v%0d_timeout", i), r_tmo, 0);
      chk($sformatf("v%0d_beats", i), nbeats(), 1);
      chk($sformatf("v%0d_adr", i), adr_at(0), vecs[i].exp_adr);
      chk($sformatf("v%0d_we_sel", i), we_sel_at(0), {3'b000, vecs[i].we, vecs[i].sel});
      chk($sformatf("v%0d_stb_cycles", i), stb_cycles - b_stb, vecs[i].dly + 2);
      chk($sformatf("v%0d_done_err", i), {done_cnt - b_done, err_cnt - b_err}, {32'd1, 32'd0});
      if (vecs[i].we) begin
        chk($sformatf("v%0d_dat_o", i), dat_at(0), vecs[i].wdata);
      end else begin
        chk($sformatf("v%0d_rdata", i), rd_at(0), vecs[i].exp_rd);
        chk($sformatf("v%0d_rv_latency", i), t_rv - t_stb, vecs[i].dly + 2);
      end
    end

    // read burst with a 3-cycle consumer stall on the second beat
    ack_dly = 0;
    mark();
    run_burst(1'b0, 32'h3000_0000, 8'd3, 4'hF, 32'h0, 1, 3, 0, 0, 0, 0);
    #1;
    chk("rb_timeout", r_tmo, 0);
    chk("rb_beats", nbeats(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rb_adr%0d", i), adr_at(i), 32'h3000_0000 + 32'(4 * i));
      chk($sformatf("rb_rdata%0d", i), rd_at(i), rd_word(32'h3000_0000 + 32'(4 * i)));
    end
    chk("rb_stall", {r_srv, r_sstb}, {32'd3, 32'd0});
    chk("rb_stb_cycles", stb_cycles - b_stb, 8);
    chk("rb_stable", unstable - b_uns, 0);
    chk("rb_err", r_err, 0);

    // timeout: responder silent, 3-beat read is abandoned after the first beat
    resp_en = 1'b0;
    mark();
    run_burst(1'b0, 32'h3000_0100, 8'd2, 4'hF, 32'h0, -1, 0, 0, 0, 0, 0);
    chk("to_err_at_done", {r_tmo, r_err}, 2'b01);
    @(negedge clk); #1;
    chk("to_err_clears", {done, err, cmd_ready}, 3'b001);
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("to_stb_cycles", stb_cycles - b_stb, TO);
    chk("to_beats", nbeats(), 1);
    chk("to_adr", adr_at(0), 32'h3000_0100);
    chk("to_done_err", {done_cnt - b_done, err_cnt - b_err}, {32'd1, 32'd1});
    chk("to_no_rdata", rd_q.size(), 0);

    // address wrap
    mark();
    run_burst(1'b0, 32'hFFFF_FFFC, 8'd1, 4'hF, 32'h0, -1, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_adr0", adr_at(0), 32'hFFFF_FFFC);
    chk("wrap_adr1", adr_at(1), 32'h0000_0000);
    chk("wrap_rdata", {rd_at(0), rd_at(1)}, {32'h5AFF_FFFC, 32'hA500_0000});
    repeat (2) @(negedge clk);

    // spurious acks in IDLE
    mark();
    #1 spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("spur_idle", {cmd_ready, wbm_stb_o, done}, 3'b100);
    chk("spur_idle_cnt", {stb_cycles - b_stb, done_cnt - b_done}, 0);
    spur_ack = 1'b0;

    // write burst with acks in FETCH and a command held valid throughout
    mark();
    run_burst(1'b1, 32'h2000_0000, 8'd1, 4'hF, 32'h5500_0000, -1, 0, 1, 2, 1, 0);
    #1;
    chk("hold_beats", nbeats(), 2);
    chk("hold_adr", {adr_at(0), adr_at(1)}, {32'h2000_0000, 32'h2000_0004});
    chk("hold_dat", {dat_at(0), dat_at(1)}, {32'h5500_0000, 32'h5500_0001});
    chk("hold_early_accept", r_early, 0);
    chk("hold_done_err", {done_cnt - b_done, err_cnt - b_err}, {32'd1, 32'd0});
    mark();
    run_burst(1'b1, 32'h2000_0000, 8'd1, 4'hF, 32'h6600_0000, -1, 0, 0, 0, 0, 0);
    #1;
    chk("second_cmd_wait", r_accw, 0);
    chk("second_cmd_beats", nbeats(), 2);
    repeat (2) @(negedge clk);

    // read burst with acks during RESP while the consumer stalls
    mark();
    run_burst(1'b0, 32'h2000_0040, 8'd1, 4'hF, 32'h0, 0, 2, 1, 0, 0, 0);
    #1;
    chk("spur_resp_rdata", {rd_at(0), rd_at(1)}, {rd_word(32'h2000_0040), rd_word(32'h2000_0044)});
    chk("spur_resp_beats", nbeats(), 2);
    chk("spur_resp_err", {r_tmo, r_err, r_srv}, {1'b0, 1'b0, 32'd2});
    repeat (2) @(negedge clk);

    // reset while stb is high in beat 2 of a 4-beat write
    mark();
    run_burst(1'b1, 32'h4000_0000, 8'd3, 4'hF, 32'h7700_0000, -1, 0, 0, 0, 0, 2);
    chk("rst_reached", r_tmo, 0);
    @(negedge clk); #1;
    chk("midrst_bus", {wbm_cyc_o, wbm_stb_o, done, cmd_ready}, 4'b0001);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_done", done_cnt - b_done, 0);
    chk("midrst_beats", nbeats(), 2);
    mark();
    run_burst(1'b1, 32'h4000_0010, 8'd0, 4'h9, 32'h1357_9BDF, -1, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_adr_dat", {adr_at(0), dat_at(0)}, {32'h4000_0010, 32'h1357_9BDF});
    chk("post_rst_we_sel", we_sel_at(0), 8'h19);
    chk("post_rst_done", {r_tmo, r_err, done_cnt - b_done}, {1'b0, 1'b0, 32'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
